// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug protocol initiator: command bytes, response codes,
// initiator FSM states and the frame-length rule.
package debug_pkg;

   localparam logic [7:0] CMD_PING  = 8'h50;
   localparam logic [7:0] CMD_HALT  = 8'h48;
   localparam logic [7:0] CMD_GO    = 8'h47;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] ACK       = 8'h41;

   typedef enum logic [1:0] {
      RspOk      = 2'b00,
      RspBadAck  = 2'b01,
      RspTimeout = 2'b10,
      RspBadCmd  = 2'b11
   } rsp_status_t;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StTxIssue = 4'd1,
      StTxWait  = 4'd2,
      StRxWait  = 4'd3,
      StResp    = 4'd4
   } state_t;

   // Number of bytes in a command frame; 0 marks an unknown command.
   function automatic logic [3:0] frame_len(input logic [7:0] cmd);
      case (cmd)
         CMD_PING, CMD_HALT, CMD_GO: frame_len = 4'd1;
         CMD_READ:                   frame_len = 4'd5;
         CMD_WRITE:                  frame_len = 4'd9;
         default:                    frame_len = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/debug_initiator_uart.sv
// 8N1 UART transceiver: one start bit, 8 data bits LSB first, one stop bit.
// CLKS_PER_BIT clock cycles per bit (must be >= 2); RX samples mid-bit after a 2-flop sync.
module debug_initiator_uart #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx_serial,
   input  logic [7:0] tx_byte,
   input  logic       tx_start,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       tx_busy,
   output logic       tx_serial,
   output logic [3:0] dbg
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [9:0]    tx_shift_q;
   logic [3:0]    tx_bit_q;
   logic [CW-1:0] tx_clk_q;
   logic          tx_busy_q;

   logic [1:0]    rx_sync_q;
   logic          rx_busy_q;
   logic [3:0]    rx_bit_q;
   logic [CW-1:0] rx_clk_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          rx_in;

   assign rx_in = rx_sync_q[1];

   // Shift register idles all-ones so the line stays high between frames.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_shift_q <= '1;
         tx_bit_q   <= 4'd0;
         tx_clk_q   <= '0;
         tx_busy_q  <= 1'b0;
      end else if (!tx_busy_q) begin
         if (tx_start) begin
            tx_shift_q <= {1'b1, tx_byte, 1'b0};
            tx_bit_q   <= 4'd0;
            tx_clk_q   <= '0;
            tx_busy_q  <= 1'b1;
         end
      end else if (tx_clk_q == BIT_LAST) begin
         tx_clk_q   <= '0;
         tx_shift_q <= {1'b1, tx_shift_q[9:1]};
         tx_bit_q   <= tx_bit_q + 4'd1;
         if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
         end
      end else begin
         tx_clk_q <= tx_clk_q + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_sync_q  <= 2'b11;
         rx_busy_q  <= 1'b0;
         rx_bit_q   <= 4'd0;
         rx_clk_q   <= '0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], rx_serial};
         rx_valid_q <= 1'b0;
         if (!rx_busy_q) begin
            if (!rx_in) begin
               rx_busy_q <= 1'b1;
               rx_bit_q  <= 4'd0;
               rx_clk_q  <= '0;
            end
         end else if (rx_clk_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST)) begin
            rx_clk_q <= '0;
            if (rx_bit_q == 4'd0) begin
               // A start bit that is gone by mid-bit was a glitch.
               if (rx_in) rx_busy_q <= 1'b0;
               else       rx_bit_q  <= 4'd1;
            end else if (rx_bit_q == 4'd9) begin
               rx_busy_q  <= 1'b0;
               rx_valid_q <= rx_in;
            end else begin
               rx_data_q <= {rx_in, rx_data_q[7:1]};
               rx_bit_q  <= rx_bit_q + 4'd1;
            end
         end else begin
            rx_clk_q <= rx_clk_q + CW'(1);
         end
      end
   end

   assign tx_serial = tx_shift_q[0];
   assign tx_busy   = tx_busy_q;
   assign rx_byte   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign dbg       = {tx_busy_q, rx_busy_q, rx_in, tx_shift_q[0]};

endmodule

// File: rtl/debug_initiator.sv
// Host end of the UART debug protocol: turns word-level requests into command frames and
// parses the target's ack or 4-byte read reply into one response per request.
module debug_initiator
   import debug_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned CLKS_PER_BIT   = 868
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [31:0] rsp_rdata,
   input  logic        rx_serial,
   output logic        tx_serial,
   output logic [7:0]  dbg_state
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   rsp_status_t status_q, status_d;
   logic [7:0]  cmd_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  tx_idx_q, tx_idx_d, tx_idx_inc;
   logic [1:0]  rx_cnt_q, rx_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        armed_q, armed_d;
   logic        ready_q;
   logic        accept;

   logic [7:0]  tx_byte, rx_byte;
   logic        tx_start, tx_busy, rx_valid;
   logic [3:0]  uart_dbg;

   debug_initiator_uart #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .CLK      (CLK),
      .RST      (RST),
      .rx_serial(rx_serial),
      .tx_byte  (tx_byte),
      .tx_start (tx_start),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .tx_busy  (tx_busy),
      .tx_serial(tx_serial),
      .dbg      (uart_dbg)
   );

   assign accept     = req_valid && ready_q;
   assign tx_idx_inc = tx_idx_q + 4'd1;

   always_comb begin
      case (tx_idx_q)
         4'd0:    tx_byte = cmd_q;
         4'd1:    tx_byte = addr_q[31:24];
         4'd2:    tx_byte = addr_q[23:16];
         4'd3:    tx_byte = addr_q[15:8];
         4'd4:    tx_byte = addr_q[7:0];
         4'd5:    tx_byte = wdata_q[31:24];
         4'd6:    tx_byte = wdata_q[23:16];
         4'd7:    tx_byte = wdata_q[15:8];
         4'd8:    tx_byte = wdata_q[7:0];
         default: tx_byte = cmd_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      tx_idx_d = tx_idx_q;
      rx_cnt_d = rx_cnt_q;
      tmo_d    = tmo_q;
      armed_d  = armed_q;
      tx_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               tx_idx_d = 4'd0;
               rx_cnt_d = 2'd0;
               rdata_d  = 32'h0;
               if (frame_len(req_cmd) == 4'd0) begin
                  status_d = RspBadCmd;
                  state_d  = StResp;
               end else begin
                  state_d = StTxIssue;
               end
            end
         end
         StTxIssue: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               armed_d  = 1'b0;
               state_d  = StTxWait;
            end
         end
         StTxWait: begin
            // First cycle only lets tx_busy rise before looking for its fall.
            if (!armed_q) begin
               armed_d = 1'b1;
            end else if (!tx_busy) begin
               tx_idx_d = tx_idx_inc;
               if (tx_idx_inc == frame_len(cmd_q)) begin
                  tmo_d   = '0;
                  state_d = StRxWait;
               end else begin
                  state_d = StTxIssue;
               end
            end
         end
         StRxWait: begin
            if (rx_valid) begin
               tmo_d = '0;
               if (cmd_q == CMD_READ) begin
                  rdata_d  = {rdata_q[23:0], rx_byte};
                  rx_cnt_d = rx_cnt_q + 2'd1;
                  if (rx_cnt_q == 2'd3) begin
                     status_d = RspOk;
                     state_d  = StResp;
                  end
               end else begin
                  status_d = (rx_byte == ACK) ? RspOk : RspBadAck;
                  state_d  = StResp;
               end
            end else if (tmo_q == TMO_LAST) begin
               status_d = RspTimeout;
               rx_cnt_d = 2'd0;
               state_d  = StResp;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         status_q <= RspOk;
         rdata_q  <= 32'h0;
         tx_idx_q <= 4'd0;
         rx_cnt_q <= 2'd0;
         tmo_q    <= '0;
         armed_q  <= 1'b0;
         ready_q  <= 1'b0;
         cmd_q    <= 8'h00;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         tx_idx_q <= tx_idx_d;
         rx_cnt_q <= rx_cnt_d;
         tmo_q    <= tmo_d;
         armed_q  <= armed_d;
         ready_q  <= (state_d == StIdle);
         if (accept) begin
            cmd_q   <= req_cmd;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   assign req_ready  = ready_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_status = status_q;
   assign rsp_rdata  = rdata_q;
   assign dbg_state  = {state_q, uart_dbg};

endmodule
